// File: rtl/mix_columns_seq.sv
// AES MixColumns stage: captures one 16-byte state and mixes COLS_PER_CYCLE columns per clock.
// Optional MIXCOL_INV_EN adds the inv_mode port and InvMixColumns coefficients.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         last_round,
`ifdef MIXCOL_INV_EN
    input  logic         inv_mode,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    // state   | meaning
    // S_IDLE  | waiting for a state from shift_row
    // S_BUSY  | mixing columns r_col_cnt.. into r_result
    // S_DONE  | holding r_out until add_round_key takes it
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t         r_fsm;
    logic [1:0]     r_col_cnt;
    logic [127:0]   r_state;
    logic [127:0]   r_result;
    logic [127:0]   r_out;
    logic           r_in_ready;
    logic           r_out_valid;
`ifdef MIXCOL_INV_EN
    logic           r_inv;
`endif
    logic [127:0]   w_result_nxt;
    logic           w_last_col;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] d [4];
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            a[i] = c[31-8*i -: 8];
            d[i] = xt(a[i]);
        end
        for (int i = 0; i < 4; i++) begin
            r[31-8*i -: 8] = d[i] ^ d[(i+1)%4] ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
        end
        return r;
    endfunction

`ifdef MIXCOL_INV_EN
    // 9/b/d/e built from x2, x4, x8 so no generic GF multiplier is needed
    function automatic logic [31:0] mix_inv(input logic [31:0] c);
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] a, x2, x4, x8;
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            a     = c[31-8*i -: 8];
            x2    = xt(a);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a;
            mb[i] = x8 ^ x2 ^ a;
            md[i] = x8 ^ x4 ^ a;
            me[i] = x8 ^ x4 ^ x2;
        end
        for (int i = 0; i < 4; i++) begin
            r[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
        end
        return r;
    endfunction
`endif

    always_comb begin
        w_result_nxt = r_result;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            int idx;
            idx = int'(r_col_cnt) + k;
`ifdef MIXCOL_INV_EN
            w_result_nxt[127-32*idx -: 32] = r_inv ? mix_inv(r_state[127-32*idx -: 32])
                                                   : mix_fwd(r_state[127-32*idx -: 32]);
`else
            w_result_nxt[127-32*idx -: 32] = mix_fwd(r_state[127-32*idx -: 32]);
`endif
        end
    end

    assign w_last_col = (r_col_cnt == 2'(4 - COLS_PER_CYCLE));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_fsm       <= S_IDLE;
            r_col_cnt   <= '0;
            r_state     <= '0;
            r_result    <= '0;
            r_out       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef MIXCOL_INV_EN
            r_inv       <= 1'b0;
`endif
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_state    <= state_in;
                        r_in_ready <= 1'b0;
`ifdef MIXCOL_INV_EN
                        r_inv      <= inv_mode;
`endif
                        if (last_round) begin
                            r_result    <= state_in;
                            r_out       <= state_in;
                            r_out_valid <= 1'b1;
                            r_fsm       <= S_DONE;
                        end else begin
                            r_col_cnt <= '0;
                            r_fsm     <= S_BUSY;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_BUSY: begin
                    r_result <= w_result_nxt;
                    if (w_last_col) begin
                        r_out       <= w_result_nxt;
                        r_out_valid <= 1'b1;
                        r_col_cnt   <= '0;
                        r_fsm       <= S_DONE;
                    end else begin
                        r_col_cnt <= r_col_cnt + 2'(COLS_PER_CYCLE);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_fsm       <= S_IDLE;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign state_out = r_out;

endmodule
